// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register-dump reader: FSM states and default sizes.
// The CSUM state is only reachable when the design is built with DUMP_CHECKSUM_EN.
package reg_dump_reader_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_CSUM = 2'd3
  } dump_state_e;

  // Register index increment that wraps at the register count, not at the
  // power of two implied by the index width.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_dump_reader.sv
// Debug master that walks a register range through one register-file read port
// and streams (index, value) beats on valid/ready. Optional macro: DUMP_CHECKSUM_EN.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rf_rs,
  input  logic [DATA_W-1:0] rf_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_csum,
  output logic              busy,
  output logic              done
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] rs_hold_q, rs_hold_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              csum_q, csum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              handshake;
  logic [ADDR_W-1:0] cur_inc;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  assign handshake = valid_q & out_ready;
  assign cur_inc   = ADDR_W'(wrap_inc(int'(cur_q), NUM_REGS));

  // The read address is live only in READ; elsewhere it parks on the last index read.
  assign rf_rs     = (state_q == ST_READ) ? cur_q : rs_hold_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_csum  = csum_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      end_q     <= '0;
      rs_hold_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      csum_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      end_q     <= end_d;
      rs_hold_q <= rs_hold_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      last_q    <= last_d;
      csum_q    <= csum_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DUMP_CHECKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    end_d     = end_q;
    rs_hold_d = rs_hold_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    data_d    = data_q;
    last_d    = last_q;
    csum_d    = csum_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    acc_d     = acc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = first_idx;
          end_d   = last_idx;
          busy_d  = 1'b1;
          state_d = ST_READ;
`ifdef DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end

      ST_READ: begin
        rs_hold_d = cur_q;
        idx_d     = cur_q;
        data_d    = rf_rd;
        csum_d    = 1'b0;
        valid_d   = 1'b1;
        state_d   = ST_SEND;
`ifdef DUMP_CHECKSUM_EN
        last_d    = 1'b0;
        acc_d     = acc_q ^ rf_rd;
`else
        last_d    = (cur_q == end_q);
`endif
      end

      ST_SEND: begin
        if (handshake) begin
          valid_d = 1'b0;
          if (cur_q != end_q) begin
            cur_d   = cur_inc;
            state_d = ST_READ;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            // The accumulator already includes the last data word captured in READ.
            valid_d = 1'b1;
            idx_d   = end_q;
            data_d  = acc_q;
            last_d  = 1'b1;
            csum_d  = 1'b1;
            state_d = ST_CSUM;
`else
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
`endif
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (handshake) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: register-file model, beat scoreboard,
// directed scenarios. Honours DUMP_CHECKSUM_EN the same way the design does.
module tb_reg_dump_reader;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        csum;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic [4:0]  rf_rs;
  logic [31:0] rf_rd;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_csum;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  beat_t       expQ[$];
  int          hsCyc[$];
  int          cyc;
  int          compared;
  int          mismatched;

  reg_dump_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .rf_rs     (rf_rs),
    .rf_rd     (rf_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_csum  (out_csum),
    .busy      (busy),
    .done      (done)
  );

  assign rf_rd = regs[rf_rs];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats are sampled at the negedge before the edge that completes the handshake.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      hsCyc.push_back(cyc);
      checkOutput("beat_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("beat_idx",  32'(out_idx),  32'(e.idx));
        checkOutput("beat_data", out_data,      e.data);
        checkOutput("beat_last", 32'(out_last), 32'(e.last));
        checkOutput("beat_csum", 32'(out_csum), 32'(e.csum));
      end
    end
  end

  // Reference model of one dump, taken from the register contents at call time.
  task automatic pushDump(input int first, input int last);
    int          i;
    logic [31:0] acc;
    beat_t       b;
    bit          csumEn;
    i   = first;
    acc = '0;
`ifdef DUMP_CHECKSUM_EN
    csumEn = 1'b1;
`else
    csumEn = 1'b0;
`endif
    for (int n = 0; n < 32; n++) begin
      b.idx  = 5'(i);
      b.data = regs[i];
      b.last = !csumEn && (i == last);
      b.csum = 1'b0;
      expQ.push_back(b);
      acc = acc ^ regs[i];
      if (i == last) break;
      i = (i + 1) % 32;
    end
    if (csumEn) begin
      b.idx  = 5'(last);
      b.data = acc;
      b.last = 1'b1;
      b.csum = 1'b1;
      expQ.push_back(b);
    end
  endtask

  task automatic applyStimulus(input int first, input int last);
    pushDump(first, last);
    @(posedge clk);
    #1;
    first_idx = 5'(first);
    last_idx  = 5'(last);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (out_valid === 1'b1) found = 1'b1;
    end
    checkOutput("wait_valid_timeout", 32'(found), 32'd1);
  endtask

  task automatic waitDone(input int budget);
    bit found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
    end
    checkOutput("wait_done_timeout", 32'(found), 32'd1);
    checkOutput("busy_low_with_done", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rf_rs"},  32'(rf_rs),     32'd0);
    checkOutput({tag, "_valid"},  32'(out_valid), 32'd0);
    checkOutput({tag, "_idx"},    32'(out_idx),   32'd0);
    checkOutput({tag, "_data"},   out_data,       32'd0);
    checkOutput({tag, "_last"},   32'(out_last),  32'd0);
    checkOutput({tag, "_csum"},   32'(out_csum),  32'd0);
    checkOutput({tag, "_busy"},   32'(busy),      32'd0);
    checkOutput({tag, "_done"},   32'(done),      32'd0);
  endtask

  initial begin
    bit found;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    rst        = 1'b1;
    start      = 1'b0;
    first_idx  = '0;
    last_idx   = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    regs[0] = 32'h0;
    regs[1] = 32'h11;
    regs[2] = 32'h22;
`ifdef DUMP_CHECKSUM_EN
    regs[3] = 32'h44;
`else
    regs[3] = 32'h33;
`endif

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] basic dump 1..3");
    hsCyc.delete();
    applyStimulus(1, 3);
    @(negedge clk);
    checkOutput("read_cycle_valid_low", 32'(out_valid), 32'd0);
    checkOutput("busy_during_dump", 32'(busy), 32'd1);
    waitDone(40);
    checkOutput("basic_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("basic_hs_count", 32'(hsCyc.size()), 32'(expQ.size() == 0 ? hsCyc.size() : 0));
    if (hsCyc.size() >= 3) begin
      checkOutput("throughput_1_2", 32'(hsCyc[1] - hsCyc[0]), 32'd2);
      checkOutput("throughput_2_3", 32'(hsCyc[2] - hsCyc[1]), 32'd2);
    end

    $display("[TB] wrap-around dump 30..1");
    applyStimulus(30, 1);
    waitDone(60);
    checkOutput("wrap_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] backpressure on beat 2");
    out_ready = 1'b0;
    applyStimulus(1, 3);
    waitValid(20);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    waitValid(20);
    for (int n = 0; n < 5; n++) begin
      checkOutput("stall_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_idx",   32'(out_idx),   32'd2);
      checkOutput("stall_data",  out_data,       32'h22);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDone(40);
    checkOutput("stall_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] reset during beat 2");
    out_ready = 1'b0;
    applyStimulus(1, 3);
    waitValid(20);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    waitValid(20);
    expQ.delete();
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(5, 5);
    waitDone(40);
    checkOutput("single_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] start while busy and write during READ");
    applyStimulus(1, 3);
    @(posedge clk);
    #1;
    first_idx = 5'd7;
    last_idx  = 5'd9;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (busy === 1'b1 && out_valid === 1'b0 && rf_rs === 5'd2) found = 1'b1;
    end
    checkOutput("find_read_idx2", 32'(found), 32'd1);
    @(posedge clk);
    regs[2] <= 32'hAA;
    waitDone(40);
    repeat (3) @(negedge clk);
    checkOutput("busy_start_ignored", 32'(busy), 32'd0);
    checkOutput("ignored_queue_empty", 32'(expQ.size()), 32'd0);
    regs[2] = 32'h22;

    $display("[TB] start in the done cycle");
    pushDump(4, 4);
    @(posedge clk);
    #1;
    first_idx = 5'd4;
    last_idx  = 5'd4;
    start     = 1'b1;
    @(posedge clk);
    #1;
    first_idx = 5'd6;
    last_idx  = 5'd6;
    pushDump(6, 6);
    waitDone(40);
    checkOutput("start_on_done_busy", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone(40);
    checkOutput("back_to_back_queue_empty", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
